pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Parametrised supervisor for an iCE40 SB_PLL40_CORE instance; runs on the PLL reference clock (12 MHz board clock).
- Drives the PLL RESETB pin and filters the asynchronous PLL LOCK signal.
- Issues timed PLL reset pulses, retries on lock timeout, and releases a clean synchronous system reset only after lock has been stable.
- Re-sequences on lock loss and reports status and fault counters to the rest of the design (VGA pipeline, game logic).

Parameters:
- SYNC_STAGES, 2, number of flops synchronising pll_lock_i (≥2).
- PLL_RST_CYCLES, 16, cycles pll_resetb_o is held low per reset attempt (≥1).
- LOCK_TIMEOUT, 12000, maximum cycles spent in WAIT_LOCK+STABLE per attempt before retry (≥ LOCK_STABLE_CYCLES+1).
- LOCK_STABLE_CYCLES, 1200, consecutive cycles synced lock must be high (≥1).
- HOLD_CYCLES, 64, extra cycles sys_rst_o is held after stable lock (≥1).
- MAX_RETRIES, 8, timeouts allowed before FAIL; 0 = retry forever.
- CNT_W, 8, width of retry and loss counters.

Ports:
- clk_i, input, 1, reference clock.
- rst_i, input, 1, synchronous active-high reset.
- pll_lock_i, input, 1, raw PLL LOCK; asynchronous to clk_i.
- pll_resetb_o, output, 1, to PLL RESETB; low = PLL held in reset.
- sys_rst_o, output, 1, synchronous active-high reset for downstream logic.
- ready_o, output, 1, high while in RUN.
- fail_o, output, 1, high in FAIL (sticky until rst_i).
- loss_pulse_o, output, 1, one-cycle pulse on lock loss in RUN.
- retry_cnt_o, output, CNT_W, timeouts in the current acquisition.
- loss_cnt_o, output, CNT_W, lock-loss events since rst_i; saturating.
- state_o, output, 3, current state encoding for debug: PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAIL=5.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State becomes PLL_RST; all timers and sync flops are 0.
  - pll_resetb_o=0, sys_rst_o=1, ready_o=0, fail_o=0, loss_pulse_o=0, counters=0.
  - Reset mid-operation aborts any state identically.
- All outputs are registered; no combinational path from pll_lock_i. lock_s is pll_lock_i after SYNC_STAGES flops.
- PLL_RST:
  - pll_resetb_o=0 and phase timer increments.
  - When the timer reaches PLL_RST_CYCLES-1, go to WAIT_LOCK, clear the phase timer and the timeout timer, and set pll_resetb_o=1.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - Timeout timer increments.
  - If lock_s=1, go to STABLE with stable counter 0.
- STABLE:
  - Timeout timer keeps running; stable counter increments while lock_s=1.
  - If lock_s=0, go to WAIT_LOCK (stable counter cleared, timeout timer not cleared).
  - When the stable counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, go to HOLD.
- Timeout (WAIT_LOCK or STABLE, timeout timer = LOCK_TIMEOUT-1):
  - Stable completion in the same cycle has priority over timeout.
  - Otherwise retry_cnt increments (saturating).
  - If MAX_RETRIES≠0 and the new count equals MAX_RETRIES, go to FAIL; else go to PLL_RST.
- HOLD:
  - sys_rst_o stays 1; phase timer counts HOLD_CYCLES.
  - If lock_s drops, go to WAIT_LOCK (not counted as loss).
  - At the end of the count, go to RUN; retry_cnt is cleared.
- RUN:
  - sys_rst_o=0 and ready_o=1, both effective from the first RUN cycle.
  - If lock_s=0: loss_pulse_o=1 for exactly one cycle, loss_cnt increments (saturating at 2^CNT_W-1), go to PLL_RST.
  - sys_rst_o=1 and ready_o=0 from the next cycle.
- FAIL:
  - pll_resetb_o=0, sys_rst_o=1, fail_o=1, ready_o=0.
  - Only rst_i exits this state.
- Counter widths: timers sized $clog2 of their maximum; no wrap of any timer is reachable.
- Latency from rst_i release with pll_lock_i tied high: ready_o rises after exactly PLL_RST_CYCLES+1+LOCK_STABLE_CYCLES+HOLD_CYCLES edges.

Test Plan:
Bench parameters for all scenarios: SYNC=2, PLL_RST=4, TIMEOUT=20, STABLE=8, HOLD=5, RETRIES=2, CNT_W=4.
- Lock tied high, release rst_i:
  - pll_resetb_o low for exactly 4 edges.
  - ready_o and ~sys_rst_o rise at edge 18; state_o sequence 0,1,2,3,4.
- Lock never asserts:
  - Two PLL reset pulses of 4 cycles each, 20 cycles apart in WAIT_LOCK.
  - After the second timeout, fail_o=1, state_o=5, retry_cnt_o=2, pll_resetb_o=0, held indefinitely.
- Lock glitches (high 5 cycles, low 1 cycle, repeated), then steady:
  - STABLE restarts on each drop; HOLD is never entered during the glitches.
  - Timeout fires at cycle 20 of the attempt and retry_cnt_o=1.
  - After lock is steady, RUN is reached and retry_cnt_o clears to 0.
- In RUN, drop pll_lock_i for 3 cycles:
  - loss_pulse_o high exactly one cycle, 2 cycles after the drop.
  - loss_cnt_o=1 and sys_rst_o=1 the following cycle; PLL_RST is re-entered and the sequence re-acquires.
- Force 20 lock losses:
  - loss_cnt_o saturates at 15 and never wraps.
- Assert rst_i for 1 cycle while in HOLD and while in FAIL:
  - Next cycle all outputs return to their reset values and state_o=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Sequences the iCE40 PLL reset, filters its asynchronous LOCK output and
// releases a clean synchronous system reset only after lock has proven stable.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 12000,
  parameter int LOCK_STABLE_CYCLES = 1200,
  parameter int HOLD_CYCLES        = 64,
  parameter int MAX_RETRIES        = 8,
  parameter int CNT_W              = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pll_lock_i,
  output logic             pll_resetb_o,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic             loss_pulse_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [2:0]       state_o
);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  // The phase timer is shared by PLL_RST and HOLD, so it covers the longer of the two.
  localparam int PHASE_MAX = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W    = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PHASE_W-1:0] RST_LAST   = PHASE_W'(PLL_RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   RETRY_LIM  = CNT_W'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  logic [2:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]   retry_inc;
  logic               timeout;
  logic               loss_evt;

  logic pll_resetb_q, sys_rst_q, ready_q, fail_q, loss_pulse_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign timeout   = (tmo_q == TMO_LAST);
  assign retry_inc = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tmo_d    = tmo_q;
    stab_d   = stab_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    loss_evt = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          phase_d = '0;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (timeout) begin
          retry_d = retry_inc;
          phase_d = '0;
          stab_d  = '0;
          state_d = (MAX_RETRIES != 0 && retry_inc == RETRY_LIM) ? ST_FAIL : ST_PLL_RST;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (lock_s) begin
            state_d = ST_STABLE;
            stab_d  = '0;
          end
        end
      end

      ST_STABLE: begin
        // A stable window completing on the timeout cycle still wins.
        if (lock_s && stab_q == STAB_LAST) begin
          state_d = ST_HOLD;
          phase_d = '0;
        end else if (timeout) begin
          retry_d = retry_inc;
          phase_d = '0;
          stab_d  = '0;
          state_d = (MAX_RETRIES != 0 && retry_inc == RETRY_LIM) ? ST_FAIL : ST_PLL_RST;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            stab_d  = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (!lock_s) begin
          // Lock dropped before release: give the new wait a full timeout window.
          state_d = ST_WAIT_LOCK;
          tmo_d   = '0;
          stab_d  = '0;
        end else if (phase_q == HOLD_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
          loss_d   = (loss_q == CNT_MAX) ? loss_q : loss_q + 1'b1;
          state_d  = ST_PLL_RST;
          phase_d  = '0;
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_PLL_RST;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as state_q and never depend combinationally on pll_lock_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_PLL_RST;
      phase_q      <= '0;
      tmo_q        <= '0;
      stab_q       <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      loss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tmo_q        <= tmo_d;
      stab_q       <= stab_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= !(state_d == ST_PLL_RST || state_d == ST_FAIL);
      sys_rst_q    <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
      loss_pulse_q <= loss_evt;
    end
  end

  assign pll_resetb_o = pll_resetb_q;
  assign sys_rst_o    = sys_rst_q;
  assign ready_o      = ready_q;
  assign fail_o       = fail_q;
  assign loss_pulse_o = loss_pulse_q;
  assign retry_cnt_o  = retry_q;
  assign loss_cnt_o   = loss_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters;
// expected edge numbers are hand-derived from the sequencing rules.
module tb_pll_lock_supervisor;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             pll_lock_i;
  logic             pll_resetb_o;
  logic             sys_rst_o;
  logic             ready_o;
  logic             fail_o;
  logic             loss_pulse_o;
  logic [CNT_W-1:0] retry_cnt_o;
  logic [CNT_W-1:0] loss_cnt_o;
  logic [2:0]       state_o;

  int checks = 0;
  int errors = 0;

  logic [2:0]       st_log [0:63];
  logic             rb_log [0:63];
  logic [CNT_W-1:0] rt_log [0:63];

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .HOLD_CYCLES        (5),
    .MAX_RETRIES        (2),
    .CNT_W              (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pll_lock_i   (pll_lock_i),
    .pll_resetb_o (pll_resetb_o),
    .sys_rst_o    (sys_rst_o),
    .ready_o      (ready_o),
    .fail_o       (fail_o),
    .loss_pulse_o (loss_pulse_o),
    .retry_cnt_o  (retry_cnt_o),
    .loss_cnt_o   (loss_cnt_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic hold_reset(input logic lock);
    rst_i      = 1'b1;
    pll_lock_i = lock;
    step();
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  state_o, 0);
    check({tag, "_resetb"}, pll_resetb_o, 0);
    check({tag, "_sysrst"}, sys_rst_o, 1);
    check({tag, "_ready"},  ready_o, 0);
    check({tag, "_fail"},   fail_o, 0);
    check({tag, "_pulse"},  loss_pulse_o, 0);
    check({tag, "_retry"},  retry_cnt_o, 0);
    check({tag, "_loss"},   loss_cnt_o, 0);
  endtask

  // Drop lock for three cycles while in RUN and wait for re-acquisition.
  task automatic lose_and_reacquire(input int exp_loss, input bit detail);
    int n;
    pll_lock_i = 1'b0;
    step();
    step();
    if (detail) check("loss_pulse_early", loss_pulse_o, 0);
    step();
    check("loss_pulse", loss_pulse_o, 1);
    check("loss_cnt", loss_cnt_o, exp_loss);
    if (detail) begin
      check("loss_sysrst", sys_rst_o, 1);
      check("loss_ready", ready_o, 0);
      check("loss_state", state_o, 0);
    end
    pll_lock_i = 1'b1;
    step();
    if (detail) check("loss_pulse_width", loss_pulse_o, 0);
    n = 1;
    while (!ready_o && n < 40) begin
      step();
      n++;
    end
    if (detail) check("reacq_latency", n, 18);
    else        check("reacq_ready", ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rb, first_rdy, first_nsr, first_rt, drops, hold_seen, bad;

    // Lock tied high from reset release.
    hold_reset(1'b1);
    check_reset_values("por");
    rst_i = 1'b0;
    first_rb = -1; first_rdy = -1; first_nsr = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      st_log[i] = state_o;
      if (pll_resetb_o && first_rb < 0) first_rb = i;
      if (ready_o && first_rdy < 0) first_rdy = i;
      if (!sys_rst_o && first_nsr < 0) first_nsr = i;
    end
    check("resetb_rise_edge", first_rb, 4);
    check("ready_rise_edge", first_rdy, 18);
    check("sysrst_fall_edge", first_nsr, 18);
    check("st_edge3", st_log[3], 0);
    check("st_edge4", st_log[4], 1);
    check("st_edge5", st_log[5], 2);
    check("st_edge12", st_log[12], 2);
    check("st_edge13", st_log[13], 3);
    check("st_edge17", st_log[17], 3);
    check("st_edge18", st_log[18], 4);

    // Lock loss in RUN, then saturate the loss counter.
    lose_and_reacquire(1, 1'b1);
    for (int t = 2; t <= 20; t++) lose_and_reacquire((t > 15) ? 15 : t, 1'b0);
    check("loss_cnt_sat", loss_cnt_o, 15);

    // One-cycle reset while in HOLD.
    hold_reset(1'b1);
    rst_i = 1'b0;
    for (int i = 1; i <= 13; i++) step();
    check("in_hold", state_o, 3);
    rst_i = 1'b1;
    step();
    check_reset_values("hold_rst");
    rst_i = 1'b0;

    // Lock never asserts: two attempts then FAIL.
    hold_reset(1'b0);
    rst_i = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step();
      st_log[i] = state_o;
      rb_log[i] = pll_resetb_o;
      rt_log[i] = retry_cnt_o;
    end
    check("nl_rb_edge3", rb_log[3], 0);
    check("nl_rb_edge4", rb_log[4], 1);
    check("nl_rb_edge23", rb_log[23], 1);
    check("nl_rb_edge24", rb_log[24], 0);
    check("nl_retry_edge24", rt_log[24], 1);
    check("nl_rb_edge27", rb_log[27], 0);
    check("nl_rb_edge28", rb_log[28], 1);
    check("nl_st_edge47", st_log[47], 1);
    check("nl_st_edge48", st_log[48], 5);
    check("nl_retry_edge48", rt_log[48], 2);
    check("nl_rb_edge48", rb_log[48], 0);
    bad = 0;
    for (int i = 48; i <= 60; i++) if (st_log[i] != 3'd5 || rb_log[i]) bad++;
    check("nl_fail_sticky", bad, 0);
    check("nl_fail_flag", fail_o, 1);
    rst_i = 1'b1;
    step();
    check_reset_values("fail_rst");
    rst_i = 1'b0;

    // Glitching lock (high 5, low 1) for one attempt, then steady.
    hold_reset(1'b0);
    rst_i = 1'b0;
    st_log[0] = 3'd0;
    first_rt = -1; first_rdy = -1; drops = 0; hold_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      pll_lock_i = (i <= 24) ? ((i % 6) != 0) : 1'b1;
      step();
      st_log[i] = state_o;
      rt_log[i] = retry_cnt_o;
      if (i <= 24 && st_log[i-1] == 3'd2 && st_log[i] == 3'd1) drops++;
      if (i <= 24 && st_log[i] == 3'd3) hold_seen++;
      if (retry_cnt_o == 1 && first_rt < 0) first_rt = i;
      if (ready_o && first_rdy < 0) first_rdy = i;
    end
    check("gl_stable_restarts", drops, 3);
    check("gl_no_hold", hold_seen, 0);
    check("gl_timeout_edge", first_rt, 24);
    check("gl_ready_edge", first_rdy, 42);
    check("gl_retry_before_run", rt_log[41], 1);
    check("gl_retry_cleared", rt_log[42], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
